// File: rtl/fc_parallel_engine.sv
// fc_parallel_engine
//   Fully-connected inference layer computing LANES output neurons at once.
//   Each lane multiplies the streamed input vector by its neuron's weight row
//   into a wide signed accumulator, then adds the bias, rounds half-up,
//   saturates to DATA_W and optionally applies ReLU. Results leave through a
//   valid/ready port, one lane per handshake, group after group.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start               begin a pass (only honoured while idle)
//   busy, done          pass in progress / one-cycle end-of-pass pulse
//   in_rd, in_addr      read strobe and index into the external input buffer
//   in_data             input sample, valid the cycle after in_rd
//   w_wr_*              weight write port, address = neuron*IN_SIZE + k (idle only)
//   b_wr_*              bias write port, address = neuron (idle only)
//   out_valid/ready     result handshake
//   out_addr, out_data  neuron index and signed result
module fc_parallel_engine #(
  parameter int IN_SIZE   = 120,
  parameter int OUT_SIZE  = 10,
  parameter int LANES     = 2,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int RELU_EN   = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  in_rd,
  output logic [$clog2(IN_SIZE)-1:0]            in_addr,
  input  logic [DATA_W-1:0]                     in_data,
  input  logic                                  w_wr_en,
  input  logic [$clog2(IN_SIZE*OUT_SIZE)-1:0]   w_wr_addr,
  input  logic [DATA_W-1:0]                     w_wr_data,
  input  logic                                  b_wr_en,
  input  logic [$clog2(OUT_SIZE)-1:0]           b_wr_addr,
  input  logic [DATA_W-1:0]                     b_wr_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(OUT_SIZE)-1:0]           out_addr,
  output logic [DATA_W-1:0]                     out_data
);

  localparam int KW  = $clog2(IN_SIZE);
  localparam int OW  = $clog2(OUT_SIZE);
  localparam int WAW = $clog2(IN_SIZE*OUT_SIZE);
  localparam int NG  = OUT_SIZE / LANES;
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW  = 2 * DATA_W;
  localparam int SW  = ACC_W + 2;

  localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] MAXV = SW'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(longint'(1) <<< (DATA_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_FLUSH, S_FINAL, S_EMIT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0] k;
  logic [GW-1:0] g;
  logic [LW-1:0] lane;
  logic          mac_en;

  logic signed [DATA_W-1:0] wmem [IN_SIZE*OUT_SIZE];
  logic signed [DATA_W-1:0] bmem [OUT_SIZE];

  logic signed [DATA_W-1:0] w_q      [LANES];
  logic signed [ACC_W-1:0]  acc      [LANES];
  logic        [DATA_W-1:0] res      [LANES];
  logic        [WAW-1:0]    w_rd_addr[LANES];
  logic        [OW-1:0]     b_rd_addr[LANES];
  logic signed [PW-1:0]     prod     [LANES];
  logic signed [SW-1:0]     rnd      [LANES];
  logic signed [SW-1:0]     sat      [LANES];
  logic        [DATA_W-1:0] fin      [LANES];

  logic k_last, g_last, lane_last, hs, emit_end, grp_start;

  assign k_last    = (k == KW'(IN_SIZE - 1));
  assign g_last    = (g == GW'(NG - 1));
  assign lane_last = (lane == LW'(LANES - 1));
  assign hs        = (state == S_EMIT) && out_ready;
  assign emit_end  = hs && lane_last;
  assign grp_start = ((state == S_IDLE) && start) || (emit_end && !g_last);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_ACCUM;
      S_ACCUM: if (k_last) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_FINAL;
      S_FINAL: state_nx = S_EMIT;
      S_EMIT:  if (emit_end) state_nx = g_last ? S_DONE : S_ACCUM;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    in_rd     = (state == S_ACCUM);
    out_valid = (state == S_EMIT);
  end

  assign in_addr  = k;
  assign out_addr = out_valid ? OW'(int'(g) * LANES + int'(lane)) : '0;
  assign out_data = out_valid ? res[lane] : '0;

  // Address generation, products and the bias/round/saturate/ReLU stage
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_rd_addr[l] = WAW'((int'(g) * LANES + int'(l)) * IN_SIZE + int'(k));
      b_rd_addr[l] = OW'(int'(g) * LANES + int'(l));
      prod[l]      = PW'(w_q[l]) * PW'($signed(in_data));
      rnd[l]       = (SW'(acc[l]) + (SW'(bmem[b_rd_addr[l]]) <<< FRAC_BITS) + HALF)
                     >>> FRAC_BITS;
      if (rnd[l] > MAXV)      sat[l] = MAXV;
      else if (rnd[l] < MINV) sat[l] = MINV;
      else                    sat[l] = rnd[l];
      fin[l] = sat[l][DATA_W-1:0];
      if ((RELU_EN != 0) && sat[l][SW-1]) fin[l] = '0;
    end
  end

  // Datapath. The weight is registered in the same cycle as the input read,
  // so both operands of a product line up one cycle later (mac_en).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k      <= '0;
      g      <= '0;
      lane   <= '0;
      mac_en <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        w_q[l] <= '0;
        acc[l] <= '0;
        res[l] <= '0;
      end
    end else begin
      mac_en <= (state == S_ACCUM);
      if (state == S_ACCUM) k <= k_last ? '0 : k + KW'(1);
      if ((state == S_IDLE) && start) g <= '0;
      else if (emit_end && !g_last)   g <= g + GW'(1);
      if (hs) lane <= lane_last ? '0 : lane + LW'(1);
      for (int unsigned l = 0; l < LANES; l++) begin
        if (state == S_ACCUM) w_q[l] <= wmem[w_rd_addr[l]];
        if (grp_start)   acc[l] <= '0;
        else if (mac_en) acc[l] <= acc[l] + ACC_W'(prod[l]);
        if (state == S_FINAL) res[l] <= fin[l];
      end
    end
  end

  // Parameter memories: no reset, writable only while idle
  always_ff @(posedge clk) begin
    if (w_wr_en && (state == S_IDLE)) wmem[w_wr_addr] <= w_wr_data;
    if (b_wr_en && (state == S_IDLE)) bmem[b_wr_addr] <= b_wr_data;
  end

endmodule

// File: tb/tb_fc_parallel_engine.sv
module tb_fc_parallel_engine;
  localparam int IN_SIZE  = 4;
  localparam int OUT_SIZE = 4;
  localparam int LANES    = 2;
  localparam int DATA_W   = 16;
  localparam int FRAC     = 8;
  localparam int ACC_W    = 40;
  localparam int GP       = IN_SIZE + 2 + LANES;

  logic clk, reset, start, out_ready;
  logic busy, done, in_rd, out_valid;
  logic [1:0] in_addr, out_addr;
  logic [DATA_W-1:0] in_data, out_data;
  logic w_wr_en, b_wr_en;
  logic [3:0] w_wr_addr;
  logic [1:0] b_wr_addr;
  logic [DATA_W-1:0] w_wr_data, b_wr_data;
  logic busy_r, done_r, in_rd_r, out_valid_r;
  logic [1:0] in_addr_r, out_addr_r;
  logic [DATA_W-1:0] out_data_r;

  fc_parallel_engine #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .LANES(LANES),
    .DATA_W(DATA_W), .FRAC_BITS(FRAC), .ACC_W(ACC_W), .RELU_EN(0)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_rd(in_rd), .in_addr(in_addr), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data));

  fc_parallel_engine #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .LANES(LANES),
    .DATA_W(DATA_W), .FRAC_BITS(FRAC), .ACC_W(ACC_W), .RELU_EN(1)) dut_relu (
    .clk(clk), .reset(reset), .start(start), .busy(busy_r), .done(done_r),
    .in_rd(in_rd_r), .in_addr(in_addr_r), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_addr(out_addr_r), .out_data(out_data_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int wt [IN_SIZE*OUT_SIZE];
  int bs [OUT_SIZE];
  int inb[IN_SIZE];

  // External input buffer: one-cycle read latency
  always @(posedge clk) if (in_rd) in_data <= DATA_W'(inb[in_addr]);

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int addr; int data; int rdata; } hs_t;
  hs_t hs_q[$];
  int done_cnt, done_rel;

  // Observe handshakes and done just before each rising edge
  always begin
    @(negedge clk);
    #4;
    if (out_valid && out_ready)
      hs_q.push_back('{cyc - t0, int'(out_addr), int'($signed(out_data)), int'($signed(out_data_r))});
    if (done) begin
      done_cnt++;
      done_rel = cyc - t0;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model(input int o, input bit relu);
    longint a = 0;
    longint r;
    for (int k = 0; k < IN_SIZE; k++) a += longint'(inb[k]) * longint'(wt[o*IN_SIZE+k]);
    a = a + longint'(bs[o]) * (2**FRAC) + (2**(FRAC-1));
    r = a >>> FRAC;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return int'(r);
  endfunction

  // All driving tasks are entered and left on a falling edge
  task automatic wr_w(input int a, input int v);
    w_wr_en = 1'b1; w_wr_addr = 4'(a); w_wr_data = DATA_W'(v);
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  task automatic wr_b(input int a, input int v);
    b_wr_en = 1'b1; b_wr_addr = 2'(a); b_wr_data = DATA_W'(v);
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < IN_SIZE*OUT_SIZE; i++) wr_w(i, wt[i]);
    for (int o = 0; o < OUT_SIZE; o++) wr_b(o, bs[o]);
  endtask

  task automatic start_pass();
    hs_q.delete();
    done_cnt = 0;
    done_rel = -1;
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_results(input string tag, input bit timing);
    check($sformatf("%s_hs_count", tag), hs_q.size(), OUT_SIZE);
    for (int i = 0; i < hs_q.size() && i < OUT_SIZE; i++) begin
      check($sformatf("%s_addr%0d", tag, i), hs_q[i].addr, i);
      check($sformatf("%s_data%0d", tag, i), hs_q[i].data, model(i, 1'b0));
      check($sformatf("%s_relu%0d", tag, i), hs_q[i].rdata, model(i, 1'b1));
      if (timing)
        check($sformatf("%s_cyc%0d", tag, i), hs_q[i].c,
              (IN_SIZE + 3) + (i / LANES) * GP + (i % LANES));
    end
  endtask

  task automatic set_identity();
    for (int o = 0; o < OUT_SIZE; o++) begin
      bs[o] = 0;
      for (int k = 0; k < IN_SIZE; k++) wt[o*IN_SIZE+k] = (o == k) ? 256 : 0;
    end
    for (int k = 0; k < IN_SIZE; k++) inb[k] = 256 * (k + 1);
  endtask

  typedef struct { int in_v; int w_v; int b_v; bit all; int exp; int exp_r; } tv_t;
  tv_t tv[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int a0, d0;
    bit seen;
    tv[0] = '{1,      128,    0, 1'b0, 1,      1};
    tv[1] = '{1,      127,    0, 1'b0, 0,      0};
    tv[2] = '{-1,     384,    0, 1'b0, -1,     0};
    tv[3] = '{-1,     512,    0, 1'b0, -2,     0};
    tv[4] = '{0,      0,      5, 1'b0, 5,      5};
    tv[5] = '{32767,  32767,  0, 1'b1, 32767,  32767};
    tv[6] = '{32767,  -32768, 0, 1'b1, -32768, 0};

    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_rd", in_rd, 0);
    check("rst_in_addr", in_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Identity scenario with full timing
    set_identity();
    load_all();
    start_pass();
    check("ident_busy", busy, 1);
    wait_done();
    check_results("ident", 1'b1);
    for (int i = 0; i < hs_q.size(); i++)
      check($sformatf("ident_const%0d", i), hs_q[i].data, 256 * (i + 1));
    check("ident_done_cyc", done_rel, OUT_SIZE / LANES * GP + 1);
    check("ident_done_cnt", done_cnt, 1);
    @(negedge clk);
    check("ident_idle", busy, 0);

    // Rounding / saturation / ReLU table
    for (int t = 0; t < 7; t++) begin
      for (int o = 0; o < OUT_SIZE; o++) begin
        bs[o] = tv[t].b_v;
        for (int k = 0; k < IN_SIZE; k++)
          wt[o*IN_SIZE+k] = (tv[t].all || k == 0) ? tv[t].w_v : 0;
      end
      for (int k = 0; k < IN_SIZE; k++) inb[k] = (tv[t].all || k == 0) ? tv[t].in_v : 0;
      load_all();
      start_pass();
      wait_done();
      check($sformatf("tv%0d_hs_count", t), hs_q.size(), OUT_SIZE);
      for (int i = 0; i < hs_q.size(); i++) begin
        check($sformatf("tv%0d_data%0d", t, i), hs_q[i].data, tv[t].exp);
        check($sformatf("tv%0d_relu%0d", t, i), hs_q[i].rdata, tv[t].exp_r);
      end
    end

    // Backpressure at the first EMIT
    set_identity();
    load_all();
    out_ready = 1'b0;
    start_pass();
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("bp_valid_cyc", seen ? cyc - t0 : -1, IN_SIZE + 3);
    a0 = int'(out_addr);
    d0 = int'($signed(out_data));
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_addr_%0d", i), out_addr, a0);
      check($sformatf("bp_data_%0d", i), $signed(out_data), d0);
      check($sformatf("bp_in_rd_%0d", i), in_rd, 0);
    end
    out_ready = 1'b1;
    wait_done();
    check_results("bp", 1'b0);
    check("bp_first_hs_cyc", hs_q.size() > 0 ? hs_q[0].c : -1, IN_SIZE + 3 + 5);
    check("bp_done_cyc", done_rel, 22);
    @(negedge clk);

    // Reset during ACCUM cycle 3, then rerun without reloading
    start_pass();
    @(negedge clk);
    @(negedge clk);
    check("abort_in_accum", in_rd, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_rd", in_rd, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_hs", hs_q.size(), 0);
    start_pass();
    wait_done();
    check_results("rerun", 1'b1);
    check("rerun_done_cyc", done_rel, 17);
    @(negedge clk);

    // Weight write and start while busy are ignored
    start_pass();
    @(negedge clk);
    @(negedge clk);
    w_wr_en = 1'b1; w_wr_addr = 4'd0; w_wr_data = 16'd512;
    start = 1'b1;
    @(negedge clk);
    w_wr_en = 1'b0;
    start = 1'b0;
    wait_done();
    check_results("busywr", 1'b1);
    check("busywr_done_cyc", done_rel, 17);
    repeat (3) @(negedge clk);
    check("busywr_no_restart", busy, 0);
    check("busywr_done_cnt", done_cnt, 1);
    wt[0] = 512;
    wr_w(0, 512);
    start_pass();
    wait_done();
    check_results("idlewr", 1'b1);
    check("idlewr_out0", hs_q.size() > 0 ? hs_q[0].data : -99999, 512);
    @(negedge clk);

    // Random passes against the model
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < IN_SIZE*OUT_SIZE; i++) wt[i] = int'($urandom_range(0, 65535)) - 32768;
      for (int o = 0; o < OUT_SIZE; o++) bs[o] = int'($urandom_range(0, 65535)) - 32768;
      for (int k = 0; k < IN_SIZE; k++)
        inb[k] = (r < 2) ? int'($urandom_range(0, 1023)) - 512 : int'($urandom_range(0, 65535)) - 32768;
      load_all();
      start_pass();
      wait_done();
      check_results($sformatf("rand%0d", r), 1'b1);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_parallel_engine.md
# fc_parallel_engine

Parametrised fully-connected inference engine, successor to the single-lane FC layer. It computes `LANES` output neurons concurrently using signed fixed-point MACs with a wide accumulator, round-half-up, saturation and optional ReLU. It streams inputs from an external 1-cycle-latency buffer, provides a runtime weight/bias load port, and emits results over a valid/ready handshake. It sits between the last conv/pool stage and the classifier output buffer.

## Interface
- `IN_SIZE`, 120, input vector length
- `OUT_SIZE`, 10, output neurons; must be a multiple of `LANES`
- `LANES`, 2, neurons computed in parallel
- `DATA_W`, 16, signed data/weight/bias width
- `FRAC_BITS`, 8, fractional bits of the Q format (≥1)
- `ACC_W`, 40, accumulator width; must be ≥ 2*DATA_W+clog2(IN_SIZE)+1
- `RELU_EN`, 0, 1 = clamp negative results to 0
- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `start` in 1: begin a pass (sampled in IDLE only)
- `busy` out 1: pass in progress
- `done` out 1: one-cycle pulse at pass end
- `in_rd` out 1: input read strobe
- `in_addr` out clog2(IN_SIZE): input index
- `in_data` in DATA_W: signed input, valid the cycle after `in_rd`
- `w_wr_en` in 1: weight write
- `w_wr_addr` in clog2(IN_SIZE*OUT_SIZE): address = o*IN_SIZE+k
- `w_wr_data` in DATA_W: weight value
- `b_wr_en` in 1: bias write
- `b_wr_addr` in clog2(OUT_SIZE): bias index
- `b_wr_data` in DATA_W: bias value
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts
- `out_addr` out clog2(OUT_SIZE): neuron index of `out_data`
- `out_data` out DATA_W: signed result

## Operation
- States: IDLE, ACCUM, FLUSH, FINAL, EMIT, DONE. Neurons are processed in groups g = 0..OUT_SIZE/LANES-1; lane l handles neuron g*LANES+l.
- IDLE: if `start`, clear the accumulators, set g=0, and go to ACCUM.
- ACCUM: IN_SIZE cycles with `in_rd`=1 and `in_addr`=k=0..IN_SIZE-1. On the following cycle each lane adds in_data*W[neuron*IN_SIZE+k] (signed, full 2*DATA_W product) to its ACC_W accumulator. After k=IN_SIZE-1, go to FLUSH.
- FLUSH: 1 cycle. Accumulate the last product; `in_rd`=0.
- FINAL: 1 cycle. Per lane, r = (acc + (bias<<FRAC_BITS) + (1<<(FRAC_BITS-1))) >>> FRAC_BITS. Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If RELU_EN, apply max(r,0) after saturation. Latch the results into the lane output registers.
- EMIT: present lanes 0..LANES-1 in order, one per `out_valid`&&`out_ready` handshake.
  - After the last lane handshake: if this is the last group, go to DONE; otherwise clear the accumulators, increment g, and go to ACCUM.
- DONE: 1 cycle, `done`=1, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy: ignored.
- `w_wr_en`/`b_wr_en` while busy: ignored; memory unchanged. In IDLE, writes complete in 1 cycle and are visible to the next pass.
- Weight/bias memories are not cleared by reset and are uninitialised until written.
- Reset mid-pass: abort immediately to IDLE. Partial results are discarded, memories are retained, and no `done` is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `in_rd`=0, `in_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0.
- Cycle numbering: the `start`-sampling edge is cycle 0.
  - Group 0: ACCUM cycles 1..IN_SIZE, FLUSH IN_SIZE+1, FINAL IN_SIZE+2.
  - First `out_valid` in cycle IN_SIZE+3.
- Group period with `out_ready`=1: IN_SIZE+2+LANES cycles.
- `done` is high in cycle (OUT_SIZE/LANES)*(IN_SIZE+2+LANES)+1 and returns to IDLE on the next edge.
- While `out_valid`=1 and `out_ready`=0, `out_data`/`out_addr` hold stable and the next group does not start. Each stalled cycle delays `done` by 1.
- `out_valid` drops the cycle after the last lane's handshake.

## Test plan
- IN_SIZE=4, OUT_SIZE=4, LANES=2, FRAC=8. Identity weights: 256 at o==k, else 0; biases 0; inputs 256,512,768,1024. Required: out_addr 0..3 → 256,512,768,1024 in cycles 7,8,15,16; `done` in cycle 17.
- Saturation: all weights and inputs 32767, bias 0 → every output 32767. Weights -32768, inputs 32767 → every output -32768.
- Rounding and ReLU, single active term:
  - input 1, weight 128 → 1
  - input 1, weight 127 → 0
  - input -1, weight 384 → -1
  - RELU_EN=1 with input -1, weight 512 → 0
  - bias 5 with zero weights → 5
- Backpressure: hold `out_ready`=0 for 5 cycles at the first EMIT → `out_data`/`out_addr` stable, `in_rd` stays 0, values correct, `done` in cycle 22.
- Reset during ACCUM cycle 3, then `start` again → identical results to the first scenario with no reload; no `done` from the aborted pass.
- Weight write and `start` issued while busy → both ignored; the current pass is unchanged. Repeating the write in IDLE changes the next pass's output accordingly.
